// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD read/write paths: FSM states,
// command-word bit positions and default timing at a 25 MHz clock.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EHIGH = 2'd2,
    ST_ELOW  = 2'd3
  } lcd_state_t;

  // Command-word layout shared with the display writer
  localparam int CMD_RW_BIT = 8;
  localparam int CMD_RS_BIT = 9;
  localparam int CMD_E_BIT  = 10;

  localparam int T_AS_DEF      = 2;
  localparam int T_EH_DEF      = 12;
  localparam int T_EL_DEF      = 13;
  localparam int MAX_POLLS_DEF = 1024;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// Request/status and LCD pad signals of the bus reader, bundled for port use.
interface lcd_bus_reader_if;

  logic       i_start;
  logic       i_rs;
  logic       i_poll;
  logic [7:0] i_lcd_data;
  logic       o_owner;
  logic       o_RW;
  logic       o_RS;
  logic       o_E;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_data;
  logic       o_bf;
  logic [6:0] o_addr;
  logic       o_timeout;

  modport slave (
    input  i_start, i_rs, i_poll, i_lcd_data,
    output o_owner, o_RW, o_RS, o_E, o_busy, o_done,
           o_data, o_bf, o_addr, o_timeout
  );

  modport master (
    output i_start, i_rs, i_poll, i_lcd_data,
    input  o_owner, o_RW, o_RS, o_E, o_busy, o_done,
           o_data, o_bf, o_addr, o_timeout
  );

endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter for phase timing; zero is high once the loaded
// count has run out, marking the last cycle of a phase.
module lcd_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780-style read cycle engine: returns status or RAM byte, optionally
// polling the busy flag until it clears or the poll budget runs out.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_AS      = T_AS_DEF,
  parameter int T_EH      = T_EH_DEF,
  parameter int T_EL      = T_EL_DEF,
  parameter int MAX_POLLS = MAX_POLLS_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  lcd_bus_reader_if.slave   bus
);

  localparam int TMR_MAX = max3(T_AS, T_EH, T_EL);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PCNT_W  = $clog2(MAX_POLLS + 1);

  localparam logic [TMR_W-1:0]  LD_AS    = TMR_W'(T_AS - 1);
  localparam logic [TMR_W-1:0]  LD_EH    = TMR_W'(T_EH - 1);
  localparam logic [TMR_W-1:0]  LD_EL    = TMR_W'(T_EL - 1);
  localparam logic [PCNT_W-1:0] POLL_LIM = PCNT_W'(MAX_POLLS);

  lcd_state_t        state_q, state_d;
  logic              rs_q, rs_d;
  logic              poll_q, poll_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [7:0]        data_q, data_d;
  logic              timeout_q, timeout_d;
  logic              owner_q, owner_d;
  logic              rw_q, rw_d;
  logic              rs_out_q, rs_out_d;
  logic              e_q, e_d;
  logic              done_q, done_d;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;

  lcd_timer #(.W(TMR_W)) u_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    poll_d    = poll_q;
    pcnt_d    = pcnt_q;
    data_d    = data_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d   = ST_SETUP;
          rs_d      = bus.i_rs;
          // Polling only makes sense on status reads
          poll_d    = bus.i_poll & ~bus.i_rs;
          pcnt_d    = '0;
          timeout_d = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = LD_AS;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_EHIGH;
          tmr_load = 1'b1;
          tmr_val  = LD_EH;
        end
      end
      ST_EHIGH: begin
        if (tmr_zero) begin
          data_d   = bus.i_lcd_data;
          state_d  = ST_ELOW;
          tmr_load = 1'b1;
          tmr_val  = LD_EL;
        end
      end
      ST_ELOW: begin
        if (tmr_zero) begin
          if (poll_q && data_q[7] && (pcnt_q < POLL_LIM)) begin
            pcnt_d   = pcnt_q + 1'b1;
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = LD_AS;
          end else begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            // Leaving with BF still set in poll mode means the budget ran out
            timeout_d = poll_q & data_q[7];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus controls follow the next state so every output comes from a flop
    owner_d  = (state_d != ST_IDLE);
    rw_d     = (state_d != ST_IDLE);
    rs_out_d = (state_d != ST_IDLE) & rs_d;
    e_d      = (state_d == ST_EHIGH);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      pcnt_q    <= '0;
      data_q    <= 8'h00;
      timeout_q <= 1'b0;
      owner_q   <= 1'b0;
      rw_q      <= 1'b0;
      rs_out_q  <= 1'b0;
      e_q       <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs_q      <= rs_d;
      poll_q    <= poll_d;
      pcnt_q    <= pcnt_d;
      data_q    <= data_d;
      timeout_q <= timeout_d;
      owner_q   <= owner_d;
      rw_q      <= rw_d;
      rs_out_q  <= rs_out_d;
      e_q       <= e_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_owner   = owner_q;
  assign bus.o_busy    = owner_q;
  assign bus.o_RW      = rw_q;
  assign bus.o_RS      = rs_out_q;
  assign bus.o_E       = e_q;
  assign bus.o_done    = done_q;
  assign bus.o_data    = data_q;
  assign bus.o_bf      = data_q[7];
  assign bus.o_addr    = data_q[6:0];
  assign bus.o_timeout = timeout_q;

endmodule
